shfl_seq_arbiter: RTL

- Shares one serial shift-left engine between two requesters: requester 0 is the execute stage, requester 1 is the debug/monitor port.
- Each operation computes A shifted left by (index of least-significant '1' in B) + 1. If B == 0, the result is A unchanged.
- Shifting is done STEP bits per cycle to save area. The block arbitrates round-robin and holds the result until the consumer accepts it.

---
 rtl/shfl_seq_arbiter_pkg.sv | 16 +
 rtl/shfl_seq_arbiter_tz_enc.sv | 22 ++
 rtl/shfl_seq_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/shfl_seq_arbiter_pkg.sv
// Shared types for the sequential shift-left arbiter: data word, shift amount and FSM states.
package shfl_seq_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SHAMT_W    = $clog2(DATA_WIDTH) + 1;

    typedef logic [DATA_WIDTH-1:0] t_data;
    typedef logic [SHAMT_W-1:0]    t_shamt;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } t_shfl_state;

endpackage

// File: rtl/shfl_seq_arbiter_tz_enc.sv
// Trailing-zero encoder: shamt = index of lowest set bit + 1, or 0 (with zero=1) for an all-zero word.
module shfl_tz_enc
    import shfl_seq_arbiter_pkg::*;
(
    input  t_data  data,
    output t_shamt shamt,
    output logic   zero
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        shamt = '0;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            if (data[i]) begin
                shamt = t_shamt'(i + 1);
            end
        end
    end

    assign zero = (data == '0);

endmodule

// File: rtl/shfl_seq_arbiter.sv
// Round-robin shared serial shift-left engine for two requesters, STEP bits per cycle.
// Optional SHFL_SEQ_PERF_EN adds saturating op_count / stall_count outputs.
module shfl_seq_arbiter
    import shfl_seq_arbiter_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  t_data       req_a [2],
    input  t_data       req_b [2],
    output logic        out_valid,
    input  logic        out_ready,
    output t_data       out_data,
    output logic        out_id,
`ifdef SHFL_SEQ_PERF_EN
    output logic [15:0] op_count,
    output logic [15:0] stall_count,
`endif
    output logic        busy
);

    localparam t_shamt STEP_W = t_shamt'(STEP);

    t_shfl_state state_q, state_d;
    t_data       acc_q, acc_d;
    t_shamt      rem_q, rem_d;
    logic        rr_q, rr_d;
    logic        out_id_q, out_id_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        grant_c;
    t_shamt      shamt_c;
    logic        zero_c;
    t_shamt      step_n_c;

    assign grant_c = req_valid[rr_q] ? rr_q : ~rr_q;

    shfl_tz_enc u_tz_enc (
        .data  (req_b[grant_c]),
        .shamt (shamt_c),
        .zero  (zero_c)
    );

    // Next-state, datapath and combinational accept.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        rr_d      = rr_q;
        out_id_d  = out_id_q;
        req_ready = 2'b00;
        step_n_c  = '0;

        unique case (state_q)
            IDLE: begin
                if (!flush && req_valid[grant_c]) begin
                    req_ready[grant_c] = 1'b1;
                    acc_d              = req_a[grant_c];
                    out_id_d           = grant_c;
                    // tz+1 never exceeds DATA_WIDTH, so no clamp is needed.
                    rem_d              = shamt_c;
                    state_d            = zero_c ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                step_n_c = (rem_q < STEP_W) ? rem_q : STEP_W;
                acc_d    = acc_q << step_n_c;
                rem_d    = rem_q - step_n_c;
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    rr_d    = ~out_id_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything except the round-robin update of a consumed result.
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            rem_d   = '0;
        end

        if (!rst_n) begin
            req_ready = 2'b00;
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            rr_q        <= 1'b0;
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            rr_q        <= rr_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

`ifdef SHFL_SEQ_PERF_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; only rst_n clears them.
    always_comb begin
        op_cnt_d    = op_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && out_ready && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign op_count    = op_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
